// File: rtl/display_timings_cfg_if.sv
// Config port for display_timings_cfg: a valid/ready offer of a full timing set,
// plus a one-cycle reject pulse back to the loader.
interface display_timings_cfg_if #(
    parameter int unsigned CORDW = 16
);
    logic             i_cfg_valid;
    logic             o_cfg_ready;
    logic             o_cfg_err;
    logic [CORDW-2:0] i_h_res;
    logic [CORDW-2:0] i_h_fp;
    logic [CORDW-2:0] i_h_sync;
    logic [CORDW-2:0] i_h_bp;
    logic [CORDW-2:0] i_v_res;
    logic [CORDW-2:0] i_v_fp;
    logic [CORDW-2:0] i_v_sync;
    logic [CORDW-2:0] i_v_bp;
    logic             i_h_pol;
    logic             i_v_pol;

    modport master (
        output i_cfg_valid, i_h_res, i_h_fp, i_h_sync, i_h_bp,
        output i_v_res, i_v_fp, i_v_sync, i_v_bp, i_h_pol, i_v_pol,
        input  o_cfg_ready, o_cfg_err
    );

    modport slave (
        input  i_cfg_valid, i_h_res, i_h_fp, i_h_sync, i_h_bp,
        input  i_v_res, i_v_fp, i_v_sync, i_v_bp, i_h_pol, i_v_pol,
        output o_cfg_ready, o_cfg_err
    );
endinterface

// File: rtl/display_timings_cfg.sv
// Runtime-reconfigurable display timing generator. New timing is validated one cycle
// after capture and swapped in only at frame end, so a frame is never torn.
module display_timings_cfg #(
    parameter int unsigned CORDW  = 16,
    parameter int unsigned H_RES  = 640,
    parameter int unsigned H_FP   = 16,
    parameter int unsigned H_SYNC = 96,
    parameter int unsigned H_BP   = 48,
    parameter int unsigned V_RES  = 480,
    parameter int unsigned V_FP   = 10,
    parameter int unsigned V_SYNC = 2,
    parameter int unsigned V_BP   = 33,
    parameter bit          H_POL  = 1'b0,
    parameter bit          V_POL  = 1'b0
) (
    input  logic                    i_pix_clk,
    input  logic                    i_rst_n,
    display_timings_cfg_if.slave    cfg,
    output logic                    o_hs,
    output logic                    o_vs,
    output logic                    o_de,
    output logic                    o_frame,
    output logic                    o_line,
    output logic signed [CORDW-1:0] o_sx,
    output logic signed [CORDW-1:0] o_sy
);
    localparam int unsigned FW = CORDW - 1;
    localparam logic [CORDW:0] SumMax = {2'b01, {(CORDW-1){1'b0}}};

    typedef logic        [FW-1:0]    field_t;
    typedef logic signed [CORDW-1:0] coord_t;
    typedef struct packed {
        field_t res;
        field_t fp;
        field_t sync;
        field_t bp;
    } axis_t;
    typedef struct packed {
        axis_t h;
        axis_t v;
        logic  h_pol;
        logic  v_pol;
    } timing_t;
    typedef enum logic [1:0] {StIdle, StCheck, StWait} state_e;

    localparam timing_t DefaultCfg = '{
        h: '{res: field_t'(H_RES), fp: field_t'(H_FP), sync: field_t'(H_SYNC), bp: field_t'(H_BP)},
        v: '{res: field_t'(V_RES), fp: field_t'(V_FP), sync: field_t'(V_SYNC), bp: field_t'(V_BP)},
        h_pol: H_POL,
        v_pol: V_POL
    };

    // One bit wider than the coordinate so an oversized blanking total cannot alias.
    function automatic logic [CORDW:0] blank_sum(axis_t a);
        return {2'b00, a.fp} + {2'b00, a.sync} + {2'b00, a.bp};
    endfunction

    function automatic logic axis_ok(axis_t a);
        return (a.res != '0) && (a.sync != '0) && (blank_sum(a) <= SumMax);
    endfunction

    function automatic coord_t ax_sta(axis_t a);
        return coord_t'(0) - coord_t'(blank_sum(a));
    endfunction

    function automatic coord_t ax_sync_sta(axis_t a);
        return ax_sta(a) + coord_t'({1'b0, a.fp});
    endfunction

    function automatic coord_t ax_sync_end(axis_t a);
        return ax_sync_sta(a) + coord_t'({1'b0, a.sync});
    endfunction

    function automatic coord_t ax_end(axis_t a);
        return coord_t'({1'b0, a.res}) - coord_t'(1);
    endfunction

    state_e  state_q;
    timing_t act_q, pend_q, nxt_cfg;
    logic    ready_q, err_q;
    coord_t  sx_q, sy_q, sx_d, sy_d;
    coord_t  hx_end, vy_end, h_sta_n, v_sta_n;
    logic    hs_q, vs_q, de_q, frame_q, line_q;
    logic    pend_ok, line_end, frame_end, apply, hs_act, vs_act;

    always_comb begin
        pend_ok   = axis_ok(pend_q.h) && axis_ok(pend_q.v);
        hx_end    = ax_end(act_q.h);
        vy_end    = ax_end(act_q.v);
        line_end  = (sx_q == hx_end);
        frame_end = line_end && (sy_q == vy_end);
        apply     = frame_end && ((state_q == StWait) || ((state_q == StCheck) && pend_ok));
        nxt_cfg   = apply ? pend_q : act_q;
        h_sta_n   = ax_sta(nxt_cfg.h);
        v_sta_n   = ax_sta(nxt_cfg.v);

        sx_d = sx_q + coord_t'(1);
        sy_d = sy_q;
        if (frame_end) begin
            sx_d = h_sta_n;
            sy_d = v_sta_n;
        end else if (line_end) begin
            sx_d = h_sta_n;
            sy_d = sy_q + coord_t'(1);
        end

        // Strobes describe the coordinates they will sit beside, hence the next-state view.
        hs_act = (sx_d > ax_sync_sta(nxt_cfg.h)) && (sx_d <= ax_sync_end(nxt_cfg.h));
        vs_act = (sy_d > ax_sync_sta(nxt_cfg.v)) && (sy_d <= ax_sync_end(nxt_cfg.v));
    end

    always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            act_q   <= DefaultCfg;
            pend_q  <= '0;
            ready_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (apply) begin
                act_q <= pend_q;
            end
            unique case (state_q)
                StIdle: begin
                    if (cfg.i_cfg_valid && ready_q) begin
                        pend_q  <= '{
                            h: '{res: cfg.i_h_res, fp: cfg.i_h_fp, sync: cfg.i_h_sync, bp: cfg.i_h_bp},
                            v: '{res: cfg.i_v_res, fp: cfg.i_v_fp, sync: cfg.i_v_sync, bp: cfg.i_v_bp},
                            h_pol: cfg.i_h_pol,
                            v_pol: cfg.i_v_pol
                        };
                        ready_q <= 1'b0;
                        state_q <= StCheck;
                    end
                end
                StCheck: begin
                    if (!pend_ok) begin
                        err_q   <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= StIdle;
                    end else if (apply) begin
                        ready_q <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (apply) begin
                        ready_q <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sx_q    <= ax_sta(DefaultCfg.h);
            sy_q    <= ax_sta(DefaultCfg.v);
            hs_q    <= ~H_POL;
            vs_q    <= ~V_POL;
            de_q    <= 1'b0;
            frame_q <= 1'b1;
            line_q  <= 1'b1;
        end else begin
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            hs_q    <= hs_act ^ ~nxt_cfg.h_pol;
            vs_q    <= vs_act ^ ~nxt_cfg.v_pol;
            de_q    <= (sx_d >= 0) && (sy_d >= 0);
            frame_q <= (sx_d == h_sta_n) && (sy_d == v_sta_n);
            line_q  <= (sx_d == h_sta_n);
        end
    end

    // Ready is forced low while reset is held so nothing is offered into a resetting block.
    assign cfg.o_cfg_ready = ready_q & i_rst_n;
    assign cfg.o_cfg_err   = err_q;
    assign o_sx            = sx_q;
    assign o_sy            = sy_q;
    assign o_hs            = hs_q;
    assign o_vs            = vs_q;
    assign o_de            = de_q;
    assign o_frame         = frame_q;
    assign o_line          = line_q;
endmodule

// File: tb/tb_display_timings_cfg.sv
// Directed bench for display_timings_cfg using a small reset timing (15x8 frame) so
// whole frames, reconfiguration and reset can all be exercised in a few hundred cycles.
module tb_display_timings_cfg;
    localparam int unsigned CORDW = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic hs, vs, de, frame, line;
    logic signed [CORDW-1:0] sx, sy;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    int     n_de, n_line, n_frame, n_hs, n_vs, n_bad, n_err, n_rdy;
    longint sx_min, sx_max, sy_min, sy_max;
    int     n_wait;

    always #5 clk = ~clk;

    display_timings_cfg_if #(.CORDW(CORDW)) cfg_if ();

    display_timings_cfg #(
        .CORDW (CORDW),
        .H_RES (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
        .V_RES (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
        .H_POL (1'b0), .V_POL (1'b0)
    ) dut (
        .i_pix_clk (clk),
        .i_rst_n   (rst_n),
        .cfg       (cfg_if),
        .o_hs      (hs),
        .o_vs      (vs),
        .o_de      (de),
        .o_frame   (frame),
        .o_line    (line),
        .o_sx      (sx),
        .o_sy      (sy)
    );

    task automatic check(input string tag, input longint got, input longint want);
        vec_cnt++;
        if (got !== want) begin
            miss_cnt++;
            $display("FAIL %s: got %0d, want %0d", tag, got, want);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_cfg(input logic valid, input int hr, hf, hsy, hb,
                             input int vr, vf, vsy, vb, input logic hp, vp);
        cfg_if.i_cfg_valid = valid;
        cfg_if.i_h_res  = (CORDW-1)'(hr);
        cfg_if.i_h_fp   = (CORDW-1)'(hf);
        cfg_if.i_h_sync = (CORDW-1)'(hsy);
        cfg_if.i_h_bp   = (CORDW-1)'(hb);
        cfg_if.i_v_res  = (CORDW-1)'(vr);
        cfg_if.i_v_fp   = (CORDW-1)'(vf);
        cfg_if.i_v_sync = (CORDW-1)'(vsy);
        cfg_if.i_v_bp   = (CORDW-1)'(vb);
        cfg_if.i_h_pol  = hp;
        cfg_if.i_v_pol  = vp;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_sx"}, sx, -7);
        check({tag, "_sy"}, sy, -4);
        check({tag, "_frame"}, frame, 1);
        check({tag, "_line"}, line, 1);
        check({tag, "_de"}, de, 0);
        check({tag, "_hs"}, hs, 1);
        check({tag, "_vs"}, vs, 1);
        check({tag, "_ready"}, cfg_if.o_cfg_ready, 0);
        check({tag, "_err"}, cfg_if.o_cfg_err, 0);
    endtask

    // Sample n consecutive cycles, checking syncs against the expected (sta, end] windows.
    task automatic observe(input int n, input int hs_sta, hs_end, vs_sta, vs_end,
                           input logic hpol, vpol);
        logic hact, vact;
        n_de = 0; n_line = 0; n_frame = 0; n_hs = 0; n_vs = 0; n_bad = 0; n_err = 0;
        sx_min = 99999; sx_max = -99999; sy_min = 99999; sy_max = -99999;
        for (int i = 0; i < n; i++) begin
            hact = (sx > hs_sta) && (sx <= hs_end);
            vact = (sy > vs_sta) && (sy <= vs_end);
            if (hs !== (hact ^ ~hpol)) n_bad++;
            if (vs !== (vact ^ ~vpol)) n_bad++;
            if (de !== ((sx >= 0) && (sy >= 0))) n_bad++;
            if (de === 1'b1) n_de++;
            if (line === 1'b1) n_line++;
            if (frame === 1'b1) n_frame++;
            if (hs === hpol) n_hs++;
            if (vs === vpol) n_vs++;
            if (cfg_if.o_cfg_err === 1'b1) n_err++;
            if (sx < sx_min) sx_min = sx;
            if (sx > sx_max) sx_max = sx;
            if (sy < sy_min) sy_min = sy;
            if (sy > sy_max) sy_max = sy;
            step(1);
        end
    endtask

    task automatic wait_frame(input int max_cycles);
        n_wait = 0;
        n_rdy  = 0;
        while (frame !== 1'b1 && n_wait < max_cycles) begin
            if (cfg_if.o_cfg_ready === 1'b1) n_rdy++;
            step(1);
            n_wait++;
        end
    endtask

    task automatic check_default_frame(input string tag);
        observe(120, -5, -2, -3, -1, 1'b0, 1'b0);
        check({tag, "_de_cnt"}, n_de, 32);
        check({tag, "_line_cnt"}, n_line, 8);
        check({tag, "_frame_cnt"}, n_frame, 1);
        check({tag, "_hs_cnt"}, n_hs, 24);
        check({tag, "_vs_cnt"}, n_vs, 30);
        check({tag, "_strobe_bad"}, n_bad, 0);
        check({tag, "_sx_min"}, sx_min, -7);
        check({tag, "_sx_max"}, sx_max, 7);
        check({tag, "_sy_min"}, sy_min, -4);
        check({tag, "_sy_max"}, sy_max, 3);
        check({tag, "_period"}, frame, 1);
        check({tag, "_next_sx"}, sx, -7);
    endtask

    task automatic check_small_frame(input string tag);
        observe(35, -2, -1, -2, -1, 1'b1, 1'b1);
        check({tag, "_de_cnt"}, n_de, 8);
        check({tag, "_line_cnt"}, n_line, 5);
        check({tag, "_frame_cnt"}, n_frame, 1);
        check({tag, "_hs_cnt"}, n_hs, 5);
        check({tag, "_vs_cnt"}, n_vs, 7);
        check({tag, "_strobe_bad"}, n_bad, 0);
        check({tag, "_err_cnt"}, n_err, 0);
        check({tag, "_sx_min"}, sx_min, -3);
        check({tag, "_sx_max"}, sx_max, 3);
        check({tag, "_sy_min"}, sy_min, -3);
        check({tag, "_sy_max"}, sy_max, 1);
        check({tag, "_period"}, frame, 1);
        check({tag, "_next_sx"}, sx, -3);
    endtask

    initial begin
        drive_cfg(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);

        // Reset state, then the reset-time timing for one frame.
        step(2);
        check_reset("rst");
        rst_n = 1'b1;
        #1;
        check("rel_ready", cfg_if.o_cfg_ready, 1);
        check("rel_frame", frame, 1);
        step(1);
        check("rel_sx_step", sx, -6);
        check("rel_frame_drop", frame, 0);
        step(119);
        check("rel_frame_again", frame, 1);
        check_default_frame("def");

        // Mid-frame load of H 4/1/1/1 V 2/1/1/1 pol 1/1: old frame finishes first.
        step(10);
        drive_cfg(1'b1, 4, 1, 1, 1, 2, 1, 1, 1, 1'b1, 1'b1);
        step(1);
        check("load_ready_low", cfg_if.o_cfg_ready, 0);
        cfg_if.i_cfg_valid = 1'b0;
        wait_frame(200);
        check("load_wait", n_wait, 109);
        check("load_ready_hi_cnt", n_rdy, 0);
        check("load_ready_new", cfg_if.o_cfg_ready, 1);
        check("load_sx", sx, -3);
        check("load_sy", sy, -3);
        check_small_frame("small");

        // Invalid config (h_sync = 0) is rejected and leaves timing unchanged.
        step(3);
        drive_cfg(1'b1, 4, 1, 0, 1, 2, 1, 1, 1, 1'b0, 1'b0);
        step(1);
        check("inv_ready_low", cfg_if.o_cfg_ready, 0);
        check("inv_err_early", cfg_if.o_cfg_err, 0);
        cfg_if.i_cfg_valid = 1'b0;
        step(1);
        check("inv_err", cfg_if.o_cfg_err, 1);
        check("inv_ready", cfg_if.o_cfg_ready, 1);
        step(1);
        check("inv_err_once", cfg_if.o_cfg_err, 0);
        wait_frame(100);
        check("inv_wait", n_wait, 29);
        check_small_frame("inv");

        // Transfer on the frame-end cycle: one more old frame, then the new timing.
        step(34);
        check("fe_sx", sx, 3);
        check("fe_sy", sy, 1);
        drive_cfg(1'b1, 8, 2, 3, 2, 4, 1, 2, 1, 1'b0, 1'b0);
        step(1);
        cfg_if.i_cfg_valid = 1'b0;
        check("fe_old_frame", frame, 1);
        check("fe_old_sx", sx, -3);
        check("fe_ready_low", cfg_if.o_cfg_ready, 0);
        step(34);
        check("fe_ready_end", cfg_if.o_cfg_ready, 0);
        step(1);
        check("fe_new_frame", frame, 1);
        check("fe_new_sx", sx, -7);
        check("fe_new_sy", sy, -4);
        check("fe_ready_new", cfg_if.o_cfg_ready, 1);
        check_default_frame("fe");

        // A second offer while a config is pending is ignored.
        step(5);
        drive_cfg(1'b1, 4, 1, 1, 1, 2, 1, 1, 1, 1'b1, 1'b1);
        step(1);
        check("dbl_ready_low", cfg_if.o_cfg_ready, 0);
        drive_cfg(1'b1, 6, 1, 2, 1, 3, 1, 1, 1, 1'b0, 1'b0);
        step(10);
        cfg_if.i_cfg_valid = 1'b0;
        wait_frame(200);
        check("dbl_wait", n_wait, 104);
        check("dbl_sx", sx, -3);
        check_small_frame("dbl");
        check("dbl_ready_after", cfg_if.o_cfg_ready, 1);

        // Blanking-total boundary: 2^(CORDW-1)+1 rejected, exactly 2^(CORDW-1) accepted.
        step(2);
        drive_cfg(1'b1, 4, 16384, 16384, 1, 2, 1, 1, 1, 1'b1, 1'b1);
        step(1);
        cfg_if.i_cfg_valid = 1'b0;
        step(1);
        check("sum_over_err", cfg_if.o_cfg_err, 1);
        drive_cfg(1'b1, 4, 16384, 16383, 1, 2, 1, 1, 1, 1'b1, 1'b1);
        step(1);
        cfg_if.i_cfg_valid = 1'b0;
        step(1);
        check("sum_max_err", cfg_if.o_cfg_err, 0);
        check("sum_max_pending", cfg_if.o_cfg_ready, 0);

        // Reset mid-frame with that config pending: it is dropped, reset timing resumes.
        step(4);
        rst_n = 1'b0;
        #1;
        check_reset("mid_rst");
        step(1);
        rst_n = 1'b1;
        #1;
        check("mid_rel_ready", cfg_if.o_cfg_ready, 1);
        check_default_frame("post");
        check("post_ready", cfg_if.o_cfg_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule
